// File: rtl/norm_unit.sv
// Iterative left-shift normaliser that returns the shifted operand and the shift amount.
// Compile-time option: SIGNED_NORM_EN enables the signed (redundant-sign-bit) normalisation test.
module norm_unit #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AMT_W-1:0] out_amt,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WB    = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AMT_W-1:0] CNT_MAX = AMT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sreg;
    logic [AMT_W-1:0] cnt;
    logic             mode;
    logic             mode_in;
    logic             accept;
    logic             stop;
    logic             in_zero;

    function automatic logic is_norm(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn)
            return v[WIDTH-1] != v[WIDTH-2];
        else
            return v[WIDTH-1];
    endfunction

`ifdef SIGNED_NORM_EN
    assign mode_in = in_signed;
`else
    // The port stays on the interface but carries no meaning in this build.
    logic unused_signed;
    assign unused_signed = in_signed;
    assign mode_in       = 1'b0;
`endif

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign in_zero   = (in_data == '0);
    assign stop      = is_norm(sreg, mode) || (cnt == CNT_MAX);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // WB gives one registered cycle between the final shift decision and out_valid.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = in_zero ? WB : SHIFT;
            SHIFT:   if (stop) state_nx = WB;
            WB:      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sreg <= in_data;
            cnt  <= '0;
            mode <= mode_in;
        end else if (state == SHIFT && !stop) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            cnt  <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_amt  <= '0;
            out_zero <= 1'b0;
        end else if (accept && in_zero) begin
            out_data <= '0;
            out_amt  <= '0;
            out_zero <= 1'b1;
        end else if (state == SHIFT && stop) begin
            out_data <= sreg;
            out_amt  <= cnt;
            out_zero <= 1'b0;
        end
    end

endmodule
